// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pipe_pkg
// Purpose  : Shared constants and helpers for the decode-stage scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;
    localparam int CNT_W      = 2;

    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
        return (addr == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_scoreboard_if
// Purpose  : Decode/retire/squash request bundle and scoreboard status outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface decode_scoreboard_if
    import riscv_pipe_pkg::*;
#(
    parameter int NREG = riscv_pipe_pkg::NREG
) ();

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_used;
    logic                  rs2_used;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_we;
    logic                  flush_e;
    logic [REG_ADDR_W-1:0] kill_rd;
    logic                  kill_we;
    logic                  ret_we;
    logic [REG_ADDR_W-1:0] ret_rd;
    logic                  stall_d;
    logic                  issue_fire;
    logic [NREG-1:0]       busy;
    logic                  err;
    logic [31:0]           stall_cycles;

    modport master (
        output issue_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_we,
               flush_e, kill_rd, kill_we, ret_we, ret_rd,
        input  stall_d, issue_fire, busy, err, stall_cycles
    );

    modport slave (
        input  issue_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_we,
               flush_e, kill_rd, kill_we, ret_we, ret_rd,
        output stall_d, issue_fire, busy, err, stall_cycles
    );

endinterface
`default_nettype wire

// File: rtl/decode_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
// Module   : sb_counter
// Purpose  : Pending-write counter for one register; +1 / -1 / -2 per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    input  wire logic             dec,
    input  wire logic             dec2,
    output logic      [CNT_W-1:0] count,
    output logic                  zero,
    output logic                  underflow
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next;
    logic             w_under;

    // dec2 (retire + kill) never coincides with inc: a flush blocks issue.
    always_comb begin
        w_next  = r_cnt;
        w_under = 1'b0;
        if (dec2) begin
            if ({1'b0, r_cnt} >= (CNT_W+1)'(2)) begin
                w_next = r_cnt - CNT_W'(2);
            end else begin
                w_next  = '0;
                w_under = 1'b1;
            end
        end else if (dec) begin
            if (r_cnt != '0) begin
                w_next = r_cnt - CNT_W'(1) + CNT_W'(inc);
            end else begin
                w_next  = CNT_W'(inc);
                w_under = 1'b1;
            end
        end else if (inc) begin
            w_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign count     = r_cnt;
    assign zero      = (r_cnt == '0);
    assign underflow = w_under;

endmodule
`default_nettype wire

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : decode_scoreboard
// Purpose  : Per-register pending-write scoreboard; stalls decode on RAW/full.
// Revision : 1.0 - initial release
// ============================================================================
module decode_scoreboard
    import riscv_pipe_pkg::*;
#(
    parameter int NREG  = riscv_pipe_pkg::NREG,
    parameter int CNT_W = riscv_pipe_pkg::CNT_W
) (
    input  wire logic    clk,
    input  wire logic    rst,
    decode_scoreboard_if.slave sb
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0][CNT_W-1:0] w_cnt;
    logic [NREG-1:0]            w_zero;
    logic [NREG-1:0]            w_under;
    logic                       w_hazard;
    logic                       w_full;
    logic                       w_stall;
    logic                       w_fire;
    logic                       r_err;
    logic [31:0]                r_stall_cycles;

    // x0 has no counter; it reads as permanently idle.
    assign w_cnt[0]   = '0;
    assign w_zero[0]  = 1'b1;
    assign w_under[0] = 1'b0;

    assign w_hazard = (sb.rs1_used & ~is_x0(sb.rs1) & ~w_zero[sb.rs1])
                    | (sb.rs2_used & ~is_x0(sb.rs2) & ~w_zero[sb.rs2]);
    assign w_full   = sb.rd_we & ~is_x0(sb.rd) & (w_cnt[sb.rd] == CNT_MAX);
    assign w_stall  = sb.issue_valid & ~sb.flush_e & (w_hazard | w_full);
    assign w_fire   = sb.issue_valid & ~sb.flush_e & ~w_hazard & ~w_full;

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        logic w_inc;
        logic w_ret;
        logic w_kil;

        assign w_inc = w_fire & sb.rd_we & (sb.rd == REG_ADDR_W'(i));
        assign w_ret = sb.ret_we & (sb.ret_rd == REG_ADDR_W'(i));
        assign w_kil = sb.flush_e & sb.kill_we & (sb.kill_rd == REG_ADDR_W'(i));

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (w_inc),
            .dec       (w_ret ^ w_kil),
            .dec2      (w_ret & w_kil),
            .count     (w_cnt[i]),
            .zero      (w_zero[i]),
            .underflow (w_under[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (|w_under) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign sb.stall_d      = w_stall;
    assign sb.issue_fire   = w_fire;
    assign sb.busy         = ~w_zero;
    assign sb.err          = r_err;
    assign sb.stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_scoreboard
// Purpose  : Cycle table with hand-derived expectations, plus async-reset case.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_decode_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_scoreboard_if #(.NREG(32)) sbif ();

    decode_scoreboard #(
        .NREG  (32),
        .CNT_W (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif)
    );

    typedef struct {
        logic        iv;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic        fl;
        logic [4:0]  krd;
        logic        kwe;
        logic        rwe;
        logic [4:0]  rrd;
        logic        es;
        logic        ef;
        logic [31:0] eb;
        logic        ee;
        logic [31:0] esc;
    } vec_t;

    typedef struct {
        logic        es;
        logic        ef;
        logic [31:0] eb;
        logic        ee;
        logic [31:0] esc;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] b(input int n);
        return 32'h1 << n;
    endfunction

    function automatic vec_t mk(
        input logic iv, input logic [4:0] rs1, input logic u1,
        input logic [4:0] rs2, input logic u2, input logic [4:0] rd, input logic we,
        input logic fl, input logic [4:0] krd, input logic kwe,
        input logic rwe, input logic [4:0] rrd,
        input logic es, input logic ef, input logic [31:0] eb,
        input logic ee, input logic [31:0] esc);
        vec_t v;
        v.iv = iv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.we = we; v.fl = fl; v.krd = krd; v.kwe = kwe;
        v.rwe = rwe; v.rrd = rrd;
        v.es = es; v.ef = ef; v.eb = eb; v.ee = ee; v.esc = esc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        sbif.issue_valid = v.iv;
        sbif.rs1 = v.rs1;  sbif.rs1_used = v.u1;
        sbif.rs2 = v.rs2;  sbif.rs2_used = v.u2;
        sbif.rd = v.rd;    sbif.rd_we = v.we;
        sbif.flush_e = v.fl; sbif.kill_rd = v.krd; sbif.kill_we = v.kwe;
        sbif.ret_we = v.rwe; sbif.ret_rd = v.rrd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        // Cycle-by-cycle table: RAW stall on x5, full on x7, issue+retire on x9,
        // kill of x12, underflow on x4, retire on x0, retire+kill on x3, kill on x0.
        vecs.push_back(mk(1, 0,0, 0,0, 5,1, 0,0,0, 0,0,   0,1, 32'h0,        0, 0));
        vecs.push_back(mk(1, 5,1, 0,0, 6,1, 0,0,0, 0,0,   1,0, b(5),         0, 0));
        vecs.push_back(mk(1, 0,0, 5,1, 6,1, 0,0,0, 0,0,   1,0, b(5),         0, 1));
        vecs.push_back(mk(1, 5,1, 0,0, 6,1, 0,0,0, 1,5,   1,0, b(5),         0, 2));
        vecs.push_back(mk(1, 5,1, 0,0, 6,1, 0,0,0, 0,0,   0,1, 32'h0,        0, 3));
        vecs.push_back(mk(0, 0,0, 0,0, 0,0, 0,0,0, 1,6,   0,0, b(6),         0, 3));
        vecs.push_back(mk(1, 0,0, 0,0, 7,1, 0,0,0, 0,0,   0,1, 32'h0,        0, 3));
        vecs.push_back(mk(1, 0,0, 0,0, 7,1, 0,0,0, 0,0,   0,1, b(7),         0, 3));
        vecs.push_back(mk(1, 0,0, 0,0, 7,1, 0,0,0, 0,0,   0,1, b(7),         0, 3));
        vecs.push_back(mk(1, 0,0, 0,0, 7,1, 0,0,0, 0,0,   1,0, b(7),         0, 3));
        vecs.push_back(mk(1, 0,0, 0,0, 7,1, 0,0,0, 1,7,   1,0, b(7),         0, 4));
        vecs.push_back(mk(1, 0,0, 0,0, 7,1, 0,0,0, 0,0,   0,1, b(7),         0, 5));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 0,0, 0,0, 0,0, 0,0,0, 1,7, 0,0, b(7),       0, 5));
        vecs.push_back(mk(1, 0,0, 0,0, 9,1, 0,0,0, 0,0,   0,1, 32'h0,        0, 5));
        vecs.push_back(mk(1, 0,0, 0,0, 9,1, 0,0,0, 1,9,   0,1, b(9),         0, 5));
        vecs.push_back(mk(1, 0,0, 0,0, 12,1, 0,0,0, 0,0,  0,1, b(9),         0, 5));
        vecs.push_back(mk(1, 12,1, 0,0, 13,1, 1,12,1, 0,0, 0,0, b(9)|b(12),  0, 5));
        vecs.push_back(mk(0, 0,0, 0,0, 0,0, 0,0,0, 1,9,   0,0, b(9),         0, 5));
        vecs.push_back(mk(0, 0,0, 0,0, 0,0, 0,0,0, 1,4,   0,0, 32'h0,        0, 5));
        vecs.push_back(mk(0, 0,0, 0,0, 0,0, 0,0,0, 1,0,   0,0, 32'h0,        1, 5));
        vecs.push_back(mk(1, 0,0, 0,0, 3,1, 0,0,0, 0,0,   0,1, 32'h0,        1, 5));
        vecs.push_back(mk(1, 0,0, 0,0, 3,1, 0,0,0, 0,0,   0,1, b(3),         1, 5));
        vecs.push_back(mk(0, 0,0, 0,0, 0,0, 1,3,1, 1,3,   0,0, b(3),         1, 5));
        vecs.push_back(mk(0, 0,0, 0,0, 0,0, 0,0,0, 0,0,   0,0, 32'h0,        1, 5));
        vecs.push_back(mk(0, 0,0, 0,0, 0,0, 1,0,1, 0,0,   0,0, 32'h0,        1, 5));

        // Reset state with a valid, hazard-free instruction presented.
        apply(mk(1, 0,0, 0,0, 5,1, 0,0,0, 0,0, 0,0, 0, 0, 0));
        rst = 1'b1;
        @(negedge clk);
        chk("reset_stall_d",      32'(sbif.stall_d),    32'h0);
        chk("reset_issue_fire",   32'(sbif.issue_fire), 32'h1);
        chk("reset_busy",         sbif.busy,            32'h0);
        chk("reset_err",          32'(sbif.err),        32'h0);
        chk("reset_stall_cycles", sbif.stall_cycles,    32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            e.es = vecs[i].es; e.ef = vecs[i].ef; e.eb = vecs[i].eb;
            e.ee = vecs[i].ee; e.esc = vecs[i].esc;
            exp_q.push_back(e);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk($sformatf("row%0d_queue", i), 32'h0, 32'h1);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("row%0d_stall_d", i),      32'(sbif.stall_d),    32'(e.es));
                chk($sformatf("row%0d_issue_fire", i),   32'(sbif.issue_fire), 32'(e.ef));
                chk($sformatf("row%0d_busy", i),         sbif.busy,            e.eb);
                chk($sformatf("row%0d_err", i),          32'(sbif.err),        32'(e.ee));
                chk($sformatf("row%0d_stall_cycles", i), sbif.stall_cycles,    e.esc);
            end
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a RAW stall.
        apply(mk(1, 0,0, 0,0, 5,1, 0,0,0, 0,0, 0,0, 0, 0, 0));
        @(posedge clk); #1;
        apply(mk(1, 5,1, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0, 0, 0));
        @(negedge clk);
        chk("midstall_stall_d", 32'(sbif.stall_d), 32'h1);
        chk("midstall_busy",    sbif.busy,         b(5));
        rst = 1'b1;
        #1;
        chk("async_rst_stall_d",      32'(sbif.stall_d),    32'h0);
        chk("async_rst_issue_fire",   32'(sbif.issue_fire), 32'h1);
        chk("async_rst_busy",         sbif.busy,            32'h0);
        chk("async_rst_err",          32'(sbif.err),        32'h0);
        chk("async_rst_stall_cycles", sbif.stall_cycles,    32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_issue_fire", 32'(sbif.issue_fire), 32'h1);
        chk("post_rst_busy",       sbif.busy,            32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
